// File: rtl/bxu_io_fifo.sv
// Buffered ready/done byte channel from the UART receiver to the BXU input port.
// Handshake inputs are resynchronized; storage, pointers and both FSMs run on clk.
module bxu_io_fifo #(
    parameter int DATA_BITWIDTH = 8,
    parameter int DEPTH         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_BITWIDTH-1:0]   up_data,
    input  logic                       up_ready,
    output logic                       up_done,
    output logic [DATA_BITWIDTH-1:0]   dn_data,
    output logic                       dn_ready,
    input  logic                       dn_done,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {U_IDLE, U_ACK} up_state_t;
    typedef enum logic [1:0] {D_IDLE, D_OFFER, D_WAIT} dn_state_t;

    up_state_t                           up_state_q, up_state_d;
    dn_state_t                           dn_state_q, dn_state_d;
    logic [SYNC_STAGES-1:0]              ready_sync_q, ready_sync_d;
    logic [SYNC_STAGES-1:0]              done_sync_q, done_sync_d;
    logic [AW-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                       count_q, count_d;
    logic                                up_done_q, up_done_d;
    logic                                dn_ready_q, dn_ready_d;
    logic [DATA_BITWIDTH-1:0]            dn_data_q, dn_data_d;
    logic [DEPTH-1:0][DATA_BITWIDTH-1:0] mem_q;

    logic ready_s, done_s, full, empty, wr_en, pop;

    assign ready_s = ready_sync_q[SYNC_STAGES-1];
    assign done_s  = done_sync_q[SYNC_STAGES-1];
    // Full/empty use the pre-edge count, so a pop does not admit a write in the same cycle.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        ready_sync_d = {ready_sync_q[SYNC_STAGES-2:0], up_ready};
        done_sync_d  = {done_sync_q[SYNC_STAGES-2:0], dn_done};
    end

    always_comb begin
        up_state_d = up_state_q;
        up_done_d  = up_done_q;
        wr_ptr_d   = wr_ptr_q;
        wr_en      = 1'b0;
        case (up_state_q)
            U_IDLE: if (ready_s && !full) begin
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_q + AW'(1);
                up_done_d  = 1'b1;
                up_state_d = U_ACK;
            end
            U_ACK: if (!ready_s) begin
                up_done_d  = 1'b0;
                up_state_d = U_IDLE;
            end
            default: up_state_d = U_IDLE;
        endcase
    end

    always_comb begin
        dn_state_d = dn_state_q;
        dn_ready_d = dn_ready_q;
        dn_data_d  = dn_data_q;
        rd_ptr_d   = rd_ptr_q;
        pop        = 1'b0;
        case (dn_state_q)
            D_IDLE: if (!empty) begin
                dn_data_d  = mem_q[rd_ptr_q];
                dn_ready_d = 1'b1;
                dn_state_d = D_OFFER;
            end
            D_OFFER: if (done_s) begin
                pop        = 1'b1;
                rd_ptr_d   = rd_ptr_q + AW'(1);
                dn_ready_d = 1'b0;
                dn_state_d = D_WAIT;
            end
            D_WAIT: if (!done_s) dn_state_d = D_IDLE;
            default: dn_state_d = D_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_state_q   <= U_IDLE;
            dn_state_q   <= D_IDLE;
            ready_sync_q <= '0;
            done_sync_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            up_done_q    <= 1'b0;
            dn_ready_q   <= 1'b0;
            dn_data_q    <= '0;
        end else begin
            up_state_q   <= up_state_d;
            dn_state_q   <= dn_state_d;
            ready_sync_q <= ready_sync_d;
            done_sync_q  <= done_sync_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            up_done_q    <= up_done_d;
            dn_ready_q   <= dn_ready_d;
            dn_data_q    <= dn_data_d;
        end
    end

    // Contents need no reset: a cleared count makes every entry stale.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= up_data;
    end

    assign up_done  = up_done_q;
    assign dn_ready = dn_ready_q;
    assign dn_data  = dn_data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_bxu_io_fifo.sv
// Directed bench for bxu_io_fifo: pass-through, full stall, ordering/wrap,
// simultaneous write+pop, long done and reset mid-handshake.
module tb_bxu_io_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] up_data = '0;
    logic       up_ready = 1'b0;
    logic       up_done;
    logic [7:0] dn_data;
    logic       dn_ready;
    logic       dn_done = 1'b0;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    bxu_io_fifo #(.DATA_BITWIDTH(8), .DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_ready(up_ready), .up_done(up_done),
        .dn_data(dn_data), .dn_ready(dn_ready), .dn_done(dn_done),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_up_done(input logic v);
        for (int i = 0; i < 200 && up_done !== v; i++) tick();
        chk("wait_up_done", up_done, v);
    endtask

    task automatic wait_dn_ready(input logic v);
        for (int i = 0; i < 200 && dn_ready !== v; i++) tick();
        chk("wait_dn_ready", dn_ready, v);
    endtask

    task automatic push(input logic [7:0] d);
        up_data  = d;
        up_ready = 1'b1;
        wait_up_done(1'b1);
        up_ready = 1'b0;
        wait_up_done(1'b0);
    endtask

    task automatic pop(input logic [7:0] exp);
        wait_dn_ready(1'b1);
        chk("pop_data", dn_data, exp);
        dn_done = 1'b1;
        wait_dn_ready(1'b0);
        dn_done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_up_done", up_done, 0);
        chk("rst_dn_ready", dn_ready, 0);
        chk("rst_dn_data", dn_data, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        tick();

        // Pass-through with exact edge timing
        up_data  = 8'hA5;
        up_ready = 1'b1;
        tick(2);
        chk("pt_up_done_early", up_done, 0);
        tick();
        chk("pt_up_done_3", up_done, 1);
        chk("pt_count_1", count, 1);
        chk("pt_dn_ready_pre", dn_ready, 0);
        tick();
        chk("pt_dn_ready", dn_ready, 1);
        chk("pt_dn_data", dn_data, 8'hA5);
        up_ready = 1'b0;
        dn_done  = 1'b1;
        tick(2);
        chk("pt_dn_ready_hold", dn_ready, 1);
        chk("pt_count_hold", count, 1);
        tick();
        chk("pt_dn_ready_low", dn_ready, 0);
        chk("pt_up_done_low", up_done, 0);
        chk("pt_count_0", count, 0);
        dn_done = 1'b0;
        tick(4);

        // Full stall
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("full_count_16", count, 16);
        chk("full_head", dn_data, 8'h00);
        up_data  = 8'h10;
        up_ready = 1'b1;
        tick(10);
        chk("full_stall_up_done", up_done, 0);
        chk("full_stall_count", count, 16);
        dn_done = 1'b1;
        wait_dn_ready(1'b0);
        wait_up_done(1'b1);
        chk("full_refill_count", count, 16);
        up_ready = 1'b0;
        wait_up_done(1'b0);
        dn_done = 1'b0;
        for (int i = 1; i <= 16; i++) pop(8'(i));
        tick(4);
        chk("full_drained", count, 0);

        // Ordering and wrap with random pacing on both sides
        fork
            for (int i = 0; i < 40; i++) begin
                tick($urandom_range(0, 3));
                push(8'h30 + 8'(i));
            end
            for (int j = 0; j < 40; j++) begin
                tick($urandom_range(0, 12));
                pop(8'h30 + 8'(j));
            end
        join
        tick(4);
        chk("wrap_count_0", count, 0);

        // Simultaneous write and pop at count 5
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        wait_dn_ready(1'b1);
        chk("sim_count_5", count, 5);
        chk("sim_head", dn_data, 8'h60);
        up_data  = 8'h65;
        up_ready = 1'b1;
        dn_done  = 1'b1;
        tick(3);
        chk("sim_up_done", up_done, 1);
        chk("sim_dn_ready", dn_ready, 0);
        chk("sim_count_same", count, 5);
        up_ready = 1'b0;
        dn_done  = 1'b0;
        wait_up_done(1'b0);
        for (int i = 1; i <= 5; i++) pop(8'h60 + 8'(i));
        tick(4);
        chk("sim_drained", count, 0);

        // Long done: one pop per handshake
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        wait_dn_ready(1'b1);
        chk("long_head", dn_data, 8'h70);
        dn_done = 1'b1;
        tick(50);
        chk("long_count_2", count, 2);
        chk("long_dn_ready_0", dn_ready, 0);
        dn_done = 1'b0;
        tick(3);
        chk("long_still_0", dn_ready, 0);
        tick();
        chk("long_reoffer", dn_ready, 1);
        chk("long_next_data", dn_data, 8'h71);
        pop(8'h71);
        pop(8'h72);
        tick(4);
        chk("long_drained", count, 0);

        // Reset mid-handshake with up_ready held high
        for (int i = 0; i < 3; i++) push(8'h80 + 8'(i));
        up_data  = 8'h83;
        up_ready = 1'b1;
        wait_up_done(1'b1);
        chk("rm_count_4", count, 4);
        rst = 1'b1;
        #1;
        chk("rm_up_done", up_done, 0);
        chk("rm_dn_ready", dn_ready, 0);
        chk("rm_dn_data", dn_data, 0);
        chk("rm_count", count, 0);
        tick();
        rst = 1'b0;
        wait_up_done(1'b1);
        chk("rm_reaccept_count", count, 1);
        up_ready = 1'b0;
        wait_up_done(1'b0);
        pop(8'h83);
        tick(4);
        chk("rm_final_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bxu_io_fifo.md
# bxu_io_fifo

Buffered byte channel between the UART receiver's ready/done output and the BXU `io_input_*` port. Both sides use the codebase's level-based 4-phase ready/done handshake. Upstream bytes are accepted into a DEPTH-entry FIFO and offered downstream in order, so bytes arriving while the BXU is busy are not lost. Handshake inputs pass through synchronizers, so each side may run on its own clock (UART at 6.9 MHz, BXU at 5 MHz); the FIFO itself runs on one clock.

## Interface
- `DATA_BITWIDTH`, 8, byte width.
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥ 2.
- `SYNC_STAGES`, 2, flop stages on `up_ready` and `dn_done`; must be ≥ 2.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `up_data` in DATA_BITWIDTH: upstream byte; stable while `up_ready` is high.
- `up_ready` in 1: upstream byte valid (async, synchronized).
- `up_done` out 1: byte accepted; registered.
- `dn_data` out DATA_BITWIDTH: head byte; registered; stable while `dn_ready` is high.
- `dn_ready` out 1: byte offered downstream; registered.
- `dn_done` in 1: downstream has taken the byte (async, synchronized).
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- **Storage:** DEPTH×DATA_BITWIDTH register array.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is a separate register; full when count==DEPTH, empty when count==0.
- **Synchronized inputs:** `ready_s` and `done_s` are the last stage of their respective SYNC_STAGES chains.
- **Upstream FSM:**
  - U_IDLE: if `ready_s` and not full, write `up_data` at `wr_ptr`, increment `wr_ptr`, set `up_done`=1, go to U_ACK.
  - U_IDLE, full: stay in U_IDLE with `up_done`=0 (stall). Never drop or overwrite a byte.
  - U_ACK: when `ready_s`=0, set `up_done`=0 and go to U_IDLE.
  - Exactly one write per upstream handshake.
- **Downstream FSM:**
  - D_IDLE: if not empty, load `dn_data`←mem[`rd_ptr`], set `dn_ready`=1, go to D_OFFER.
  - D_OFFER: when `done_s`=1, increment `rd_ptr`, decrement count, set `dn_ready`=0, go to D_WAIT.
  - D_WAIT: when `done_s`=0, go to D_IDLE.
  - The pop occurs once per handshake, however long `dn_done` is held.
- **Simultaneous write and pop in one cycle:** both take effect and `count` is unchanged.
  - Legal when full: the pop frees a slot, but the stalled write retries on the next cycle. The full check uses the pre-edge count.
- **Reset (any time, including mid-handshake):**
  - FSMs go to U_IDLE/D_IDLE; pointers, `count`, synchronizer flops, `up_done`, `dn_ready`, `dn_data` are all cleared to 0; FIFO contents are discarded.
  - Mid-handshake, the peer sees done/ready fall and completes its own phase.
  - An upstream `up_ready` still high after reset is accepted again as a new byte.

## Timing
- `up_ready` rising to `up_done` high: SYNC_STAGES+1 edges when not full. The write to memory and `count` happen at that same edge.
- Write edge to `dn_ready` high when previously empty: +1 edge. Write-to-offer latency is SYNC_STAGES+2 edges.
- `dn_done` rising to `dn_ready` low and pop: SYNC_STAGES+1 edges.
- Next offer: one edge after D_WAIT observes `done_s`=0.
- `up_done` falls SYNC_STAGES+1 edges after `up_ready` falls.
- `dn_data` changes only on entry to D_OFFER.
- Upstream throughput is bounded at 1 byte per 2×(SYNC_STAGES+1) edges plus peer latency.

## Test plan
- **Pass-through:** reset, push 0xA5 via handshake.
  - `up_done` rises 3 edges after `up_ready` (SYNC_STAGES=2).
  - `dn_ready`=1 with `dn_data`=0xA5; `count`=1, returning to 0 after the `dn_done` handshake.
- **Full stall:** push 0x00..0x0F with the consumer idle, so `count`=16.
  - Push 0x10: `up_done` stays 0.
  - Complete one downstream handshake (reads 0x00): 0x10 is accepted, `count`=16.
- **Ordering and wrap:** 40 bytes 0x30..0x57 with random consumer delays. The output sequence is identical, so the pointers wrap twice without loss or duplication.
- **Simultaneous:** with `count`=5, align the upstream write and downstream pop to the same edge. `count` stays 5 and both bytes are correct.
- **Long done:** hold `dn_done` high for 50 cycles with `count`=3. Exactly one pop occurs (`count`=2), and `dn_ready` stays 0 until `dn_done` falls.
- **Reset mid-operation:** with `count`=4 and `up_done`=1, assert `rst` for 1 cycle.
  - Immediately: all outputs 0, `count`=0.
  - `up_ready` still high: byte re-accepted, `count`=1.
